// File: rtl/lcd_pkg.sv
// Shared constants for the LCD pixel streamer: panel size, RGB565 colours,
// pattern codes and FSM state encoding.
package lcd_pkg;

  localparam int DEF_WIDTH  = 160;
  localparam int DEF_HEIGHT = 80;
  localparam int COORD_W    = 8;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  typedef enum logic [1:0] {
    PAT_BARS     = 2'd0,
    PAT_CHECKER  = 2'd1,
    PAT_GRADIENT = 2'd2,
    PAT_SCROLL   = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_pixel_stream_if.sv
// Byte-stream bundle between a frame requester, the pixel streamer and the
// downstream SPI/LCD writer. The streamer sits on the slave side.
interface lcd_pixel_stream_if;
  logic       start;
  logic [1:0] pattern_sel;
  logic       byte_ready;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       busy;
  logic       frame_done;

  modport master (
    output start, pattern_sel, byte_ready,
    input  byte_valid, byte_data, busy, frame_done
  );

  modport slave (
    input  start, pattern_sel, byte_ready,
    output byte_valid, byte_data, busy, frame_done
  );
endinterface

// File: rtl/lcd_pattern_gen.sv
// Combinational test-pattern pixel function: (x, y, scroll offset, pattern) -> RGB565.
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] offset,
  input  pattern_e           pattern,
  output logic [15:0]        pixel
);

  localparam int BAR_W = WIDTH / 8;

  logic [COORD_W:0]   scroll_sum;
  logic [COORD_W-1:0] col;
  logic [2:0]         bar_idx;
  logic               unused_y;

  assign unused_y = ^{y[7], y[1:0]};

  always_comb begin
    scroll_sum = {1'b0, x} + {1'b0, offset};
    col        = x;
    // Both operands are below WIDTH, so one conditional subtract is a full modulo.
    if (pattern == PAT_SCROLL) begin
      if (scroll_sum >= (COORD_W+1)'(WIDTH)) begin
        col = COORD_W'(scroll_sum - (COORD_W+1)'(WIDTH));
      end else begin
        col = scroll_sum[COORD_W-1:0];
      end
    end

    bar_idx = 3'd7;
    if ((int'(col) / BAR_W) < 8) begin
      bar_idx = 3'(int'(col) / BAR_W);
    end

    pixel = RGB_BLACK;
    case (pattern)
      PAT_BARS,
      PAT_SCROLL:   pixel = bar_colour(bar_idx);
      PAT_CHECKER:  pixel = (x[3] ^ y[3]) ? RGB_BLACK : RGB_WHITE;
      PAT_GRADIENT: pixel = {y[6:2], x[7:2], 5'b0_0000};
      default:      pixel = RGB_BLACK;
    endcase
  end

endmodule

// File: rtl/lcd_pixel_stream.sv
// Streams one test-pattern frame as RGB565 bytes (high byte first); first byte 1 cycle after START.
// Holds byte, coordinates and state while BYTE_VALID is high and BYTE_READY is low.
module lcd_pixel_stream
  import lcd_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input logic                clk,
  input logic                rst_n,
  lcd_pixel_stream_if.slave  bus
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [COORD_W-1:0] off_q, off_d;
  pattern_e           pat_q, pat_d;
  logic               vld_q, vld_d;
  logic [7:0]         data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               handshake;
  logic               last_px;
  logic [15:0]        pixel;

  // Pixel is looked up from the next-cycle coordinates so the byte register
  // always matches the coordinates it is loaded alongside.
  lcd_pattern_gen #(.WIDTH(WIDTH)) u_pattern_gen (
    .x       (x_d),
    .y       (y_d),
    .offset  (off_q),
    .pattern (pat_d),
    .pixel   (pixel)
  );

  always_comb begin : fsm_comb
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    off_d     = off_q;
    pat_d     = pat_q;
    handshake = vld_q & bus.byte_ready;
    last_px   = (x_q == X_LAST) && (y_q == Y_LAST);

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          pat_d   = pattern_e'(bus.pattern_sel);
          x_d     = '0;
          y_d     = '0;
          state_d = ST_HI;
        end
      end
      ST_HI: begin
        if (handshake) state_d = ST_LO;
      end
      ST_LO: begin
        if (handshake) begin
          if (last_px) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_HI;
            if (x_q == X_LAST) begin
              x_d = '0;
              y_d = y_q + COORD_W'(1);
            end else begin
              x_d = x_q + COORD_W'(1);
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        off_d   = (off_q == X_LAST) ? '0 : off_q + COORD_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin : out_comb
    vld_d  = (state_d == ST_HI) || (state_d == ST_LO);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    data_d = data_q;
    if (state_d == ST_HI) begin
      data_d = pixel[15:8];
    end else if (state_d == ST_LO) begin
      data_d = pixel[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      off_q   <= '0;
      pat_q   <= PAT_BARS;
      vld_q   <= 1'b0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      off_q   <= off_d;
      pat_q   <= pat_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.byte_valid = vld_q;
  assign bus.byte_data  = data_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_lcd_pixel_stream.sv
// Bench for lcd_pixel_stream: full-size panel for stream/stall/reset cases,
// plus a one-row panel for back-to-back scroll frames and offset wrap.
`timescale 1ns/1ps
module tb_lcd_pixel_stream;

  localparam int W   = 160;
  localparam int H   = 80;
  localparam int FB  = 2 * W * H;
  localparam int SW  = 160;
  localparam int SH  = 1;
  localparam int SFB = 2 * SW * SH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  always #5 clk = ~clk;

  lcd_pixel_stream_if bus ();
  lcd_pixel_stream_if sbus ();

  lcd_pixel_stream #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  lcd_pixel_stream #(.WIDTH(SW), .HEIGHT(SH)) dut_s (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (sbus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference picture, written straight from the pattern definitions.
  function automatic logic [15:0] bar_of(int col, int w);
    int b;
    b = col / (w / 8);
    if (b > 7) b = 7;
    case (b)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] ref_pixel(int w, int x, int y, int off, int pat);
    int r, g;
    case (pat)
      0: return bar_of(x, w);
      1: return ((((x / 8) + (y / 8)) % 2) != 0) ? 16'h0000 : 16'hFFFF;
      2: begin
        r = (y / 4) % 32;
        g = (x / 4) % 64;
        return 16'(r * 2048 + g * 32);
      end
      default: return bar_of((x + off) % w, w);
    endcase
  endfunction

  function automatic logic [7:0] exp_byte(int w, int idx, int off, int pat);
    int p;
    logic [15:0] px;
    p  = idx / 2;
    px = ref_pixel(w, p % w, p / w, off, pat);
    return (idx % 2 == 0) ? px[15:8] : px[7:0];
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main panel model: phase 0 idle, 1 streaming, 2 frame-done cycle.
  int m_phase = 0, m_idx = 0, m_pat = 0, m_off = 0;
  int first_vld_cyc = -1, done_cyc = -1, done_cnt = 0;
  logic [7:0] cap [FB];
  logic [10:0] m_exp, m_act;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_state", 32'({bus.byte_valid, bus.busy, bus.frame_done, bus.byte_data}), 32'h0);
      m_phase = 0; m_idx = 0; m_pat = 0; m_off = 0;
    end else begin
      m_exp = {m_phase == 1, m_phase != 0, m_phase == 2,
               (m_phase == 1) ? exp_byte(W, m_idx, m_off, m_pat) : 8'h00};
      m_act = {bus.byte_valid, bus.busy, bus.frame_done, bus.byte_valid ? bus.byte_data : 8'h00};
      chk("main_stream", 32'(m_act), 32'(m_exp));
      if (bus.byte_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (bus.frame_done) begin
        done_cyc = cyc;
        done_cnt++;
      end
      if (bus.byte_valid && bus.byte_ready && m_phase == 1 && m_idx < FB) cap[m_idx] = bus.byte_data;
      case (m_phase)
        0: if (bus.start) begin
          m_phase = 1; m_idx = 0; m_pat = int'(bus.pattern_sel);
        end
        1: if (bus.byte_ready) begin
          m_idx++;
          if (m_idx == FB) m_phase = 2;
        end
        default: begin
          m_phase = 0;
          m_off = (m_off + 1) % W;
        end
      endcase
    end
  end

  // One-row panel model, recording the first two pixels of every frame.
  int s_phase = 0, s_idx = 0, s_pat = 0, s_off = 0, s_fr = 0;
  logic [15:0] s_px0 [200];
  logic [15:0] s_px1 [200];
  logic [10:0] s_exp, s_act;

  always @(negedge clk) begin
    if (!rst2_n) begin
      chk("scroll_reset_state", 32'({sbus.byte_valid, sbus.busy, sbus.frame_done, sbus.byte_data}), 32'h0);
      s_phase = 0; s_idx = 0; s_pat = 0; s_off = 0;
    end else begin
      s_exp = {s_phase == 1, s_phase != 0, s_phase == 2,
               (s_phase == 1) ? exp_byte(SW, s_idx, s_off, s_pat) : 8'h00};
      s_act = {sbus.byte_valid, sbus.busy, sbus.frame_done, sbus.byte_valid ? sbus.byte_data : 8'h00};
      chk("scroll_stream", 32'(s_act), 32'(s_exp));
      if (sbus.byte_valid && sbus.byte_ready && s_phase == 1 && s_fr < 200) begin
        case (s_idx)
          0: s_px0[s_fr][15:8] = sbus.byte_data;
          1: s_px0[s_fr][7:0]  = sbus.byte_data;
          2: s_px1[s_fr][15:8] = sbus.byte_data;
          3: s_px1[s_fr][7:0]  = sbus.byte_data;
          default: ;
        endcase
      end
      if (sbus.frame_done) s_fr++;
      case (s_phase)
        0: if (sbus.start) begin
          s_phase = 1; s_idx = 0; s_pat = int'(sbus.pattern_sel);
        end
        1: if (sbus.byte_ready) begin
          s_idx++;
          if (s_idx == SFB) s_phase = 2;
        end
        default: begin
          s_phase = 0;
          s_off = (s_off + 1) % SW;
        end
      endcase
    end
  end

  initial begin
    bus.start = 1'b0;  bus.pattern_sel = 2'd0;  bus.byte_ready = 1'b0;
    sbus.start = 1'b0; sbus.pattern_sel = 2'd3; sbus.byte_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rst2_n = 1'b1;

    fork
      begin : main_seq
        int n;
        // Frame A: bars, downstream always ready.
        @(posedge clk); #1;
        first_vld_cyc = -1; done_cnt = 0;
        bus.byte_ready = 1'b1; bus.pattern_sel = 2'd0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 30000) begin
          @(posedge clk); #1; n++;
        end
        chk("bars_frame_done_seen", 32'(done_cnt), 32'd1);
        chk("bars_byte0", 32'(cap[0]), 32'hFF);
        chk("bars_byte1", 32'(cap[1]), 32'hFF);
        chk("bars_px20_hi", 32'(cap[40]), 32'hFF);
        chk("bars_px20_lo", 32'(cap[41]), 32'hE0);
        chk("bars_frame_cycles", 32'(done_cyc - first_vld_cyc), 32'd25600);
        repeat (3) @(posedge clk);
        #1;

        // Frame B: gradient with random stalls, stray START and PATTERN_SEL toggles.
        done_cnt = 0;
        bus.pattern_sel = 2'd2; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 60000) begin
          @(posedge clk); #1;
          bus.byte_ready = ($urandom_range(0, 7) != 0);
          bus.start = (n == 500 || n == 9000);
          if (n % 1000 == 0) bus.pattern_sel = bus.pattern_sel ^ 2'b01;
          n++;
        end
        bus.start = 1'b0; bus.byte_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("gradient_single_done", 32'(done_cnt), 32'd1);
        chk("gradient_last_hi", 32'(cap[FB-2]), 32'h9C);
        chk("gradient_last_lo", 32'(cap[FB-1]), 32'hE0);

        // Reset after 1000 bytes of a bars frame.
        done_cnt = 0;
        bus.pattern_sel = 2'd0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (m_idx < 1000 && n < 5000) begin
          @(posedge clk); #1; n++;
        end
        chk("bytes_before_reset", 32'(m_idx), 32'd1000);
        rst_n = 1'b0;
        #1;
        chk("reset_immediate", 32'({bus.byte_valid, bus.busy, bus.frame_done, bus.byte_data}), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("no_done_after_reset", 32'(done_cnt), 32'd0);
        bus.pattern_sel = 2'd0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (m_idx < 4 && n < 100) begin
          @(posedge clk); #1; n++;
        end
        chk("restart_byte0", 32'(cap[0]), 32'hFF);
        chk("restart_byte1", 32'(cap[1]), 32'hFF);

        // Checker: run past pixel (8,8), then abandon the frame with reset.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.pattern_sel = 2'd1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (m_idx < 2580 && n < 5000) begin
          @(posedge clk); #1; n++;
        end
        chk("checker_px8_0_hi", 32'(cap[16]), 32'h00);
        chk("checker_px8_0_lo", 32'(cap[17]), 32'h00);
        chk("checker_px8_8_hi", 32'(cap[2576]), 32'hFF);
        chk("checker_px8_8_lo", 32'(cap[2577]), 32'hFF);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("checker_no_done", 32'(done_cnt), 32'd0);
      end

      begin : scroll_seq
        int n;
        @(posedge clk); #1;
        sbus.pattern_sel = 2'd3; sbus.byte_ready = 1'b1; sbus.start = 1'b1;
        n = 0;
        while (s_fr < 161 && n < 60000) begin
          @(posedge clk); #1; n++;
        end
        sbus.start = 1'b0;
        chk("scroll_frames", 32'(s_fr), 32'd161);
        chk("scroll_f19_px1", 32'(s_px1[19]), 32'hFFE0);
        chk("scroll_f20_px0", 32'(s_px0[20]), 32'hFFE0);
        chk("scroll_f159_px0", 32'(s_px0[159]), 32'h0000);
        chk("scroll_wrap_f160_px0", 32'(s_px0[160]), 32'hFFFF);
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
